// File: rtl/simplez_mem_arbiter.sv
// simplez_mem_arbiter: shares the single Simplez memory port between the CPU
// datapath and the serial loader/debug port. Accesses are serialised with a
// req/gnt/done handshake; the loader can freeze CPU traffic through hold.
// All state updates on the falling clock edge, like the rest of the datapath.
//
// state | meaning
// IDLE  | arbitrate between the ports and latch the winner's access
// ACC   | memory performs the access (write strobe or address sample)
// RESP  | capture read data for the owner and signal completion
module simplez_mem_arbiter #(
  parameter int DATAW = 12,
  parameter int ADDRW = 9
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             c_req,
  input  logic             c_we,
  input  logic [ADDRW-1:0] c_addr,
  input  logic [DATAW-1:0] c_wdata,
  output logic             c_gnt,
  output logic             c_done,
  output logic [DATAW-1:0] c_rdata,
  input  logic             l_req,
  input  logic             l_we,
  input  logic [ADDRW-1:0] l_addr,
  input  logic [DATAW-1:0] l_wdata,
  output logic             l_gnt,
  output logic             l_done,
  output logic [DATAW-1:0] l_rdata,
  input  logic             hold,
  output logic             hold_ack,
  output logic [ADDRW-1:0] mem_addr,
  output logic             mem_we,
  output logic [DATAW-1:0] mem_wdata,
  input  logic [DATAW-1:0] mem_rdata,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;

  // owner / last encoding: loader is 1 so reset can favour the CPU on a tie
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_LDR = 1'b1;

  state_t             r_state, w_nxt_state;
  logic               r_owner, w_nxt_owner;
  logic               r_last, w_nxt_last;
  logic [ADDRW-1:0]   r_mem_addr, w_nxt_addr;
  logic               r_mem_we, w_nxt_we;
  logic [DATAW-1:0]   r_mem_wdata, w_nxt_wdata;
  logic               r_c_gnt, w_nxt_c_gnt;
  logic               r_l_gnt, w_nxt_l_gnt;
  logic               r_c_done, w_nxt_c_done;
  logic               r_l_done, w_nxt_l_done;
  logic [DATAW-1:0]   r_c_rdata, w_nxt_c_rdata;
  logic [DATAW-1:0]   r_l_rdata, w_nxt_l_rdata;
  logic               r_hold_ack, w_nxt_hold_ack;

  logic               w_c_cand, w_l_cand, w_pick_l, w_take;

  // Candidate set and round-robin winner; hold only removes the CPU
  always_comb begin
    w_c_cand = c_req & ~hold;
    w_l_cand = l_req;
    w_pick_l = w_l_cand & (~w_c_cand | (r_last == OWN_CPU));
    w_take   = (r_state == IDLE) & (w_c_cand | w_l_cand);
  end

  // Next-state and registered-output decode
  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_owner   = r_owner;
    w_nxt_last    = r_last;
    w_nxt_addr    = r_mem_addr;
    w_nxt_we      = r_mem_we;
    w_nxt_wdata   = r_mem_wdata;
    w_nxt_c_gnt   = 1'b0;
    w_nxt_l_gnt   = 1'b0;
    w_nxt_c_done  = 1'b0;
    w_nxt_l_done  = 1'b0;
    w_nxt_c_rdata = r_c_rdata;
    w_nxt_l_rdata = r_l_rdata;
    // a CPU access in flight keeps the acknowledge low until it is finished
    w_nxt_hold_ack = hold & ~((r_state != IDLE) & (r_owner == OWN_CPU));
    case (r_state)
      IDLE: begin
        if (w_take) begin
          w_nxt_owner = w_pick_l ? OWN_LDR : OWN_CPU;
          w_nxt_last  = w_pick_l ? OWN_LDR : OWN_CPU;
          w_nxt_state = ACC;
          if (w_pick_l) begin
            w_nxt_addr  = l_addr;
            w_nxt_we    = l_we;
            w_nxt_wdata = l_wdata;
            w_nxt_l_gnt = 1'b1;
          end else begin
            w_nxt_addr  = c_addr;
            w_nxt_we    = c_we;
            w_nxt_wdata = c_wdata;
            w_nxt_c_gnt = 1'b1;
          end
        end
      end
      ACC: begin
        if (r_mem_we) begin
          w_nxt_we     = 1'b0;
          w_nxt_c_done = (r_owner == OWN_CPU);
          w_nxt_l_done = (r_owner == OWN_LDR);
          w_nxt_state  = IDLE;
        end else begin
          w_nxt_state = RESP;
        end
      end
      RESP: begin
        if (r_owner == OWN_LDR) begin
          w_nxt_l_rdata = mem_rdata;
          w_nxt_l_done  = 1'b1;
        end else begin
          w_nxt_c_rdata = mem_rdata;
          w_nxt_c_done  = 1'b1;
        end
        w_nxt_state = IDLE;
      end
      default: w_nxt_state = IDLE;
    endcase
  end

  // State and output registers on the falling edge; reset also kills mem_we
  always_ff @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_owner     <= OWN_CPU;
      r_last      <= OWN_LDR;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
      r_c_gnt     <= 1'b0;
      r_l_gnt     <= 1'b0;
      r_c_done    <= 1'b0;
      r_l_done    <= 1'b0;
      r_c_rdata   <= '0;
      r_l_rdata   <= '0;
      r_hold_ack  <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_owner     <= w_nxt_owner;
      r_last      <= w_nxt_last;
      r_mem_addr  <= w_nxt_addr;
      r_mem_we    <= w_nxt_we;
      r_mem_wdata <= w_nxt_wdata;
      r_c_gnt     <= w_nxt_c_gnt;
      r_l_gnt     <= w_nxt_l_gnt;
      r_c_done    <= w_nxt_c_done;
      r_l_done    <= w_nxt_l_done;
      r_c_rdata   <= w_nxt_c_rdata;
      r_l_rdata   <= w_nxt_l_rdata;
      r_hold_ack  <= w_nxt_hold_ack;
    end
  end

  assign c_gnt     = r_c_gnt;
  assign l_gnt     = r_l_gnt;
  assign c_done    = r_c_done;
  assign l_done    = r_l_done;
  assign c_rdata   = r_c_rdata;
  assign l_rdata   = r_l_rdata;
  assign mem_addr  = r_mem_addr;
  assign mem_we    = r_mem_we;
  assign mem_wdata = r_mem_wdata;
  assign hold_ack  = r_hold_ack;
  assign busy      = (r_state != IDLE);

`ifndef SYNTHESIS
  // A port is "engaged" from its grant through its done cycle; outside that,
  // a request that is not granted at this edge must still be there at the next.
  logic w_c_engaged, w_l_engaged;
  assign w_c_engaged = ((r_state != IDLE) & (r_owner == OWN_CPU)) | r_c_done;
  assign w_l_engaged = ((r_state != IDLE) & (r_owner == OWN_LDR)) | r_l_done;

  a_c_req_held: assert property (@(negedge clk) disable iff (!rstn)
    (c_req && !w_c_engaged && !(w_take && !w_pick_l)) |=> c_req);
  a_l_req_held: assert property (@(negedge clk) disable iff (!rstn)
    (l_req && !w_l_engaged && !(w_take && w_pick_l)) |=> l_req);
  a_gnt_excl: assert property (@(negedge clk) disable iff (!rstn)
    !(r_c_gnt && r_l_gnt));
`endif

endmodule

// File: tb/tb_simplez_mem_arbiter.sv
// Self-checking bench for simplez_mem_arbiter: a behavioural 512x12
// synchronous-read memory, per-port scoreboards of expected completions,
// and a monitor that checks exclusivity, pulse width and round-robin order.
module tb_simplez_mem_arbiter;
  localparam int DW = 12;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          c_req = 1'b0, c_we = 1'b0;
  logic [AW-1:0] c_addr = '0;
  logic [DW-1:0] c_wdata = '0;
  logic          l_req = 1'b0, l_we = 1'b0;
  logic [AW-1:0] l_addr = '0;
  logic [DW-1:0] l_wdata = '0;
  logic          hold = 1'b0;
  logic          c_gnt, c_done, l_gnt, l_done, hold_ack, mem_we, busy;
  logic [DW-1:0] c_rdata, l_rdata, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [AW-1:0] mem_addr;

  logic [DW-1:0] mem [0:511] = '{8: 12'o1234, default: 12'o0};

  typedef struct {bit rd; logic [DW-1:0] data;} sb_t;
  sb_t c_sb[$];
  sb_t l_sb[$];

  int errors = 0;
  int checks = 0;

  int  we_cycles = 0, l_evt = 0, c_gnt_hold = 0;
  bit  prev_cd = 0, prev_ld = 0, exp_port = 0, tie_mode = 0;

  simplez_mem_arbiter #(.DATAW(DW), .ADDRW(AW)) dut (
    .clk(clk), .rstn(rstn),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_done(c_done), .c_rdata(c_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_done(l_done), .l_rdata(l_rdata),
    .hold(hold), .hold_ack(hold_ack),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // memory model: writes and address sampling on the same falling edge as the arbiter
  always @(negedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  // monitor sampled on the rising edge, half a cycle away from DUT updates
  always @(posedge clk) begin
    sb_t e;
    if (mem_we) we_cycles <= we_cycles + 1;
    if (l_gnt | l_done) l_evt <= l_evt + 1;
    if (c_gnt & hold) c_gnt_hold <= c_gnt_hold + 1;
    if (c_gnt | l_gnt) begin
      check("gnt_excl", 32'(c_gnt & l_gnt), 0);
      check("busy_on_gnt", 32'(busy), 1);
    end
    if (c_done | l_done) check("done_excl", 32'(c_done & l_done), 0);
    if (tie_mode && (c_gnt | l_gnt)) begin
      check("rr_order", 32'(l_gnt), 32'(exp_port));
      exp_port <= ~exp_port;
    end
    if (c_done) begin
      check("c_done_width", 32'(prev_cd), 0);
      if (c_sb.size() == 0) check("c_sb_nonempty", 32'(c_sb.size()), 1);
      else begin
        e = c_sb.pop_front();
        if (e.rd) check("c_rdata", 32'(c_rdata), 32'(e.data));
      end
    end
    if (l_done) begin
      check("l_done_width", 32'(prev_ld), 0);
      if (l_sb.size() == 0) check("l_sb_nonempty", 32'(l_sb.size()), 1);
      else begin
        e = l_sb.pop_front();
        if (e.rd) check("l_rdata", 32'(l_rdata), 32'(e.data));
      end
    end
    prev_cd <= c_done;
    prev_ld <= l_done;
  end

  // one access on a port, called at a rising edge and returning at the rising
  // edge where done is seen; keep leaves req high for a back-to-back request
  task automatic access(input bit port, input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, input bit keep, output int gw);
    sb_t e;
    int  n;
    e.rd = !we;
    e.data = data;
    if (port) begin
      l_req = 1'b1; l_we = we; l_addr = addr; l_wdata = data; l_sb.push_back(e);
    end else begin
      c_req = 1'b1; c_we = we; c_addr = addr; c_wdata = data; c_sb.push_back(e);
    end
    gw = 0;
    do begin @(posedge clk); gw++; end while (!(port ? l_gnt : c_gnt) && gw < 200);
    if (!(port ? l_gnt : c_gnt)) begin
      check("gnt_timeout", 32'(port ? l_gnt : c_gnt), 1);
      if (port) begin l_req = 1'b0; void'(l_sb.pop_back()); end
      else begin c_req = 1'b0; void'(c_sb.pop_back()); end
      return;
    end
    n = 0;
    do begin @(posedge clk); n++; end while (!(port ? l_done : c_done) && n < 10);
    check("done_lat", 32'(n), we ? 1 : 2);
    if (!keep) begin
      if (port) l_req = 1'b0; else c_req = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int gw, s0, n;
    #2 rstn = 1'b0;
    #1;
    check("rst_ctrl", 32'({c_gnt, c_done, l_gnt, l_done, mem_we, busy, hold_ack}), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_rdata", 32'({c_rdata, l_rdata}), 0);
    repeat (2) @(posedge clk);
    rstn = 1'b1;

    // CPU read; the loader port must stay quiet
    s0 = l_evt;
    access(1'b0, 1'b0, 9'o010, 12'o1234, 1'b0, gw);
    check("c_first_gnt_wait", 32'(gw), 1);
    @(posedge clk);
    check("l_untouched", 32'(l_evt - s0), 0);
    check("l_rdata_idle", 32'(l_rdata), 0);

    // loader write to 9'o100, then CPU reads it back
    s0 = we_cycles;
    access(1'b1, 1'b1, 9'o100, 12'o7777, 1'b0, gw);
    check("we_shape_wr", 32'(we_cycles - s0), 1);
    check("mem_o100", 32'(mem[64]), 12'o7777);
    check("c_rdata_held", 32'(c_rdata), 12'o1234);
    s0 = we_cycles;
    access(1'b0, 1'b0, 9'o100, 12'o7777, 1'b0, gw);
    check("we_shape_rd", 32'(we_cycles - s0), 0);

    // reset while a CPU read of 9'o005 sits in ACC
    c_req = 1'b1; c_we = 1'b0; c_addr = 9'o005;
    n = 0;
    do begin @(posedge clk); n++; end while (!c_gnt && n < 20);
    check("rst_pre_gnt", 32'(c_gnt), 1);
    #1 rstn = 1'b0;
    c_req = 1'b0;
    #1;
    check("rst_mid_ctrl", 32'({c_gnt, c_done, l_gnt, l_done, mem_we, busy, hold_ack}), 0);
    check("rst_mid_addr", 32'(mem_addr), 0);
    check("rst_mid_rdata", 32'(c_rdata), 0);
    @(posedge clk);
    @(posedge clk);
    rstn = 1'b1;

    // both ports requesting continuously: CPU, loader, CPU, loader...
    tie_mode = 1'b1;
    fork
      begin
        int w;
        for (int i = 0; i < 3; i++) begin
          access(1'b0, 1'b1, AW'(9'o200 + i), DW'(12'o1000 + i), i < 2, w);
          if (i == 0) check("tie_c_first", 32'(w), 1);
          else check("rr_starve_c", 32'(w <= 3), 1);
        end
      end
      begin
        int w;
        for (int i = 0; i < 3; i++) begin
          access(1'b1, 1'b1, AW'(9'o300 + i), DW'(12'o2000 + i), i < 2, w);
          check("rr_starve_l", 32'(w <= 3), 1);
        end
      end
    join
    tie_mode = 1'b0;
    check("tie_mem_c", 32'(mem[9'o202]), 12'o1002);
    check("tie_mem_l", 32'(mem[9'o302]), 12'o2002);

    // hold raised while a CPU read is in ACC
    fork
      begin
        int w;
        access(1'b0, 1'b0, 9'o010, 12'o1234, 1'b0, w);
      end
      begin
        int k;
        k = 0;
        do begin @(posedge clk); k++; end while (!c_gnt && k < 20);
        hold = 1'b1;
        k = 0;
        do begin @(posedge clk); k++; end while (!c_done && k < 20);
        check("hold_ack_in_flight", 32'(hold_ack), 0);
        @(posedge clk);
        check("hold_ack_after", 32'(hold_ack), 1);
      end
    join

    // pending CPU read waits while the loader fills 9'o000..9'o003
    s0 = c_gnt_hold;
    fork
      begin
        int w;
        access(1'b0, 1'b0, 9'o002, 12'o4002, 1'b0, w);
      end
      begin
        int w, k;
        for (int i = 0; i < 4; i++)
          access(1'b1, 1'b1, AW'(i), DW'(12'o4000 + i), 1'b0, w);
        check("hold_blocks_cpu", 32'(c_gnt_hold - s0), 0);
        check("hold_ack_held", 32'(hold_ack), 1);
        check("hold_cpu_pending", 32'(c_sb.size()), 1);
        hold = 1'b0;
        k = 0;
        do begin @(posedge clk); k++; end while (!c_gnt && k < 20);
        check("hold_release_lat", 32'(k), 1);
        check("hold_ack_drop", 32'(hold_ack), 0);
      end
    join

    repeat (3) @(posedge clk);
    check("sb_drained", 32'(c_sb.size() + l_sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
